// File: rtl/rc4_decrypt_fsm.sv
// rc4_decrypt_fsm: RC4 keystream generation and decrypt stage.
// Runs after S[0..255] has been built in working RAM. For each message byte k:
// i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[S[i]+S[j]]; plaintext[k]=f^ROM[k].
// Optional build macro PLAINTEXT_CHECK_EN: any plaintext byte outside
// {space, a..z} sets the sticky fail flag and ends the run after that byte.
//
// Bus protocol: every access uses one shared port set. mem_sel_decrypt picks
// the target (01 S RAM, 10 encrypted ROM, 11 decrypted RAM, 00 none).
// A read holds address and select steady for READ_WAIT cycles and latches
// q_decrypt on the last of them. A write is a single cycle with wren_decrypt=1.
// All bus outputs are registered, so they never glitch within a cycle.
module rc4_decrypt_fsm #(
  parameter int MSG_LEN   = 32,
  parameter int READ_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] address_decrypt,
  output logic [7:0] data_decrypt,
  output logic       wren_decrypt,
  output logic [1:0] mem_sel_decrypt,
  input  logic [7:0] q_decrypt,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE, INC_I, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_F, RD_M, WR_D, DONE
  } state_t;

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  state_t     state, state_n;
  logic [7:0] i, i_n, j, j_n;
  logic [4:0] k, k_n;
  logic [7:0] si, si_n, sj, sj_n, f, f_n;
  logic [7:0] wait_cnt, wait_n;
  logic       rd_latch, rd_settle;

  logic       busy_n, done_n, wren_n;
  logic [7:0] addr_n, data_n;
  logic [1:0] sel_n;

`ifdef PLAINTEXT_CHECK_EN
  logic fail_set, fail_clr;

  function automatic logic is_text(input logic [7:0] b);
    return (b == 8'h20) || ((b >= 8'h61) && (b <= 8'h7A));
  endfunction
`endif

  // Read data is valid on the READ_WAIT-th cycle of a read state. RD_SI and
  // RD_SJ stay one extra cycle so j and sj are registered before the next
  // address/data is formed from them.
  assign rd_latch  = (wait_cnt == 8'(READ_WAIT - 1));
  assign rd_settle = (wait_cnt == 8'(READ_WAIT));
  assign state_dbg = state;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      f        <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      k        <= k_n;
      si       <= si_n;
      sj       <= sj_n;
      f        <= f_n;
      wait_cnt <= wait_n;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_n = state;
    i_n     = i;
    j_n     = j;
    k_n     = k;
    si_n    = si;
    sj_n    = sj;
    f_n     = f;
    wait_n  = wait_cnt;
`ifdef PLAINTEXT_CHECK_EN
    fail_set = 1'b0;
    fail_clr = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = INC_I;
          i_n     = '0;
          j_n     = '0;
          k_n     = '0;
`ifdef PLAINTEXT_CHECK_EN
          fail_clr = 1'b1;
`endif
        end
      end
      INC_I: begin
        i_n     = i + 8'd1;
        wait_n  = '0;
        state_n = RD_SI;
      end
      RD_SI: begin
        wait_n = wait_cnt + 8'd1;
        if (rd_latch) si_n = q_decrypt;
        if (rd_settle) begin
          j_n     = j + si;
          wait_n  = '0;
          state_n = RD_SJ;
        end
      end
      RD_SJ: begin
        wait_n = wait_cnt + 8'd1;
        if (rd_latch) sj_n = q_decrypt;
        if (rd_settle) begin
          wait_n  = '0;
          state_n = WR_SI;
        end
      end
      WR_SI: state_n = WR_SJ;
      WR_SJ: begin
        wait_n  = '0;
        state_n = RD_F;
      end
      RD_F: begin
        wait_n = wait_cnt + 8'd1;
        if (rd_latch) begin
          f_n     = q_decrypt;
          wait_n  = '0;
          state_n = RD_M;
        end
      end
      RD_M: begin
        wait_n = wait_cnt + 8'd1;
        if (rd_latch) begin
          wait_n  = '0;
          state_n = WR_D;
        end
      end
      WR_D: begin
        k_n     = k + 5'd1;
        state_n = (k == LAST_K) ? DONE : INC_I;
`ifdef PLAINTEXT_CHECK_EN
        if (!is_text(data_decrypt)) begin
          fail_set = 1'b1;
          state_n  = DONE;
        end
`endif
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs for the state being entered; registered below (Moore).
  // The plaintext is formed straight from the ROM byte arriving on q_decrypt.
  always_comb begin
    busy_n = 1'b0;
    done_n = 1'b0;
    wren_n = 1'b0;
    addr_n = '0;
    data_n = '0;
    sel_n  = 2'b00;
    case (state_n)
      INC_I: busy_n = 1'b1;
      RD_SI: begin busy_n = 1'b1; sel_n = 2'b01; addr_n = i_n; end
      RD_SJ: begin busy_n = 1'b1; sel_n = 2'b01; addr_n = j_n; end
      WR_SI: begin busy_n = 1'b1; sel_n = 2'b01; addr_n = i_n; data_n = sj_n; wren_n = 1'b1; end
      WR_SJ: begin busy_n = 1'b1; sel_n = 2'b01; addr_n = j_n; data_n = si_n; wren_n = 1'b1; end
      RD_F:  begin busy_n = 1'b1; sel_n = 2'b01; addr_n = si_n + sj_n; end
      RD_M:  begin busy_n = 1'b1; sel_n = 2'b10; addr_n = {3'b000, k_n}; end
      WR_D: begin
        busy_n = 1'b1;
        sel_n  = 2'b11;
        addr_n = {3'b000, k_n};
        data_n = f_n ^ q_decrypt;
        wren_n = 1'b1;
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      wren_decrypt    <= 1'b0;
      address_decrypt <= '0;
      data_decrypt    <= '0;
      mem_sel_decrypt <= 2'b00;
    end else begin
      busy            <= busy_n;
      done            <= done_n;
      wren_decrypt    <= wren_n;
      address_decrypt <= addr_n;
      data_decrypt    <= data_n;
      mem_sel_decrypt <= sel_n;
    end
  end

`ifdef PLAINTEXT_CHECK_EN
  // Sticky plaintext failure flag, cleared when a new run starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         fail <= 1'b0;
    else if (fail_clr) fail <= 1'b0;
    else if (fail_set) fail <= 1'b1;
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// tb_rc4_decrypt_fsm: bench for rc4_decrypt_fsm with a memory-handler model,
// an RC4 reference model, an expected-write queue and a bus monitor.
module tb_rc4_decrypt_fsm;

  localparam int MSG_LEN   = 32;
  localparam int READ_WAIT = 2;
  localparam int BYTE_CYC  = 6 + 4 * READ_WAIT;

  // clock / reset
  logic clk = 1'b0;
  logic reset, start;
  always #5 clk = ~clk;

  logic       busy, done, fail, wren_decrypt;
  logic [7:0] address_decrypt, data_decrypt, q_decrypt;
  logic [1:0] mem_sel_decrypt;
  logic [3:0] state_dbg;

  rc4_decrypt_fsm #(.MSG_LEN(MSG_LEN), .READ_WAIT(READ_WAIT)) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .address_decrypt(address_decrypt), .data_decrypt(data_decrypt),
    .wren_decrypt(wren_decrypt), .mem_sel_decrypt(mem_sel_decrypt),
    .q_decrypt(q_decrypt), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // memory handler model: synchronous memories, one register stage of read
  // latency so data is valid on the second cycle an address is held
  logic [7:0] s_mem [256];
  logic [7:0] rom [MSG_LEN];
  logic [7:0] dec_mem [MSG_LEN];
  logic       load_req;

  always @(posedge clk) begin
    if (load_req) begin
      for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
      for (int x = 0; x < MSG_LEN; x++) dec_mem[x] = 8'h00;
    end else if (wren_decrypt) begin
      if (mem_sel_decrypt == 2'b01) s_mem[address_decrypt] = data_decrypt;
      if (mem_sel_decrypt == 2'b11) dec_mem[address_decrypt[4:0]] = data_decrypt;
    end
    case (mem_sel_decrypt)
      2'b01:   q_decrypt <= s_mem[address_decrypt];
      2'b10:   q_decrypt <= rom[address_decrypt[4:0]];
      2'b11:   q_decrypt <= dec_mem[address_decrypt[4:0]];
      default: q_decrypt <= 8'h00;
    endcase
  end

  // reference model
  logic [7:0]  ks [MSG_LEN];
  logic [7:0]  mdl_s [256];
  logic [12:0] exp_q [$];

  task automatic gen_keystream(input int n);
    logic [7:0] ii, jj, t, idx;
    for (int x = 0; x < 256; x++) mdl_s[x] = 8'(x);
    ii = 0;
    jj = 0;
    for (int kk = 0; kk < n; kk++) begin
      ii = ii + 8'd1;
      jj = jj + mdl_s[ii];
      t = mdl_s[ii]; mdl_s[ii] = mdl_s[jj]; mdl_s[jj] = t;
      idx = mdl_s[ii] + mdl_s[jj];
      ks[kk] = mdl_s[idx];
    end
  endtask

  function automatic bit is_text(input logic [7:0] c);
    return (c == 8'h20) || (c >= 8'h61 && c <= 8'h7A);
  endfunction

  // mode 0: ROM[0]=63, ROM[1]=6F, rest encrypts random lowercase/space text
  // mode 1: random lowercase/space text with plaintext byte 3 = 'A'
  task automatic prepare(input int mode, output int n_exp, output bit exp_fail);
    logic [7:0] o;
    int r;
    gen_keystream(MSG_LEN);
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      r = $urandom_range(0, 26);
      o = (r == 26) ? 8'h20 : 8'h61 + 8'(r);
      if (mode == 1 && kk == 3) o = 8'h41;
      rom[kk] = o ^ ks[kk];
    end
    if (mode == 0) begin
      rom[0] = 8'h63;
      rom[1] = 8'h6F;
    end
    n_exp = MSG_LEN;
    exp_fail = 1'b0;
    exp_q.delete();
    for (int kk = 0; kk < MSG_LEN; kk++) begin
      o = rom[kk] ^ ks[kk];
      exp_q.push_back({5'(kk), o});
`ifdef PLAINTEXT_CHECK_EN
      if (!is_text(o)) begin
        exp_fail = 1'b1;
        n_exp = kk + 1;
        break;
      end
`endif
    end
    gen_keystream(n_exp);
  endtask

  // monitor / scoreboard
  int dec_writes = 0;
  int done_cnt   = 0;
  bit scen1_flag = 1'b0;

  always @(negedge clk) begin
    logic [12:0] e;
    if (!reset) begin
      if (wren_decrypt)
        check("wren_only_in_write", 32'(mem_sel_decrypt == 2'b01 || mem_sel_decrypt == 2'b11), 1);
      if (!busy) check("idle_mem_sel", 32'(mem_sel_decrypt), 0);
      if (mem_sel_decrypt[1]) check("msg_addr_range", 32'(address_decrypt < MSG_LEN), 1);
      if (wren_decrypt && mem_sel_decrypt == 2'b11) begin
        dec_writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_dec_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("dec_write", 32'({address_decrypt[4:0], data_decrypt}), 32'(e));
        end
        if (scen1_flag && address_decrypt == 8'd1)
          check("swap_after_byte1", 32'({s_mem[2], s_mem[3]}), 32'h0302);
      end
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic load_mem();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  task automatic run_once(input int mode, input bit poke, input bit s1);
    int n_exp, lat, w0, d0, mism;
    bit exp_fail, got;
    prepare(mode, n_exp, exp_fail);
    load_mem();
    w0 = dec_writes;
    d0 = done_cnt;
    scen1_flag = s1;
    // latency counts cycles from the start cycle through the done cycle
    start = 1'b1;
    lat = 1;
    got = 1'b0;
    while (!got && lat < 2000) begin
      @(negedge clk);
      lat++;
      start = poke && (lat == 50 || lat == 200 || lat == 333);
      if (lat == 2) check("fail_cleared_on_start", 32'(fail), 0);
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check("done_seen", 32'(got), 1);
    check("start_to_done", 32'(lat), 32'(n_exp * BYTE_CYC + 2));
    check("fail_at_done", 32'(fail), 32'(exp_fail));
    @(negedge clk);
    check("busy_after_done", 32'(busy), 0);
    check("done_one_cycle", 32'(done), 0);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt - d0), 1);
    check("write_count", 32'(dec_writes - w0), 32'(n_exp));
    check("queue_drained", 32'(exp_q.size()), 0);
    mism = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== mdl_s[x]) mism++;
    check("final_s_array", 32'(mism), 0);
    if (s1) begin
      check("byte0_plain", 32'(dec_mem[0]), 32'h61);
      check("byte1_plain", 32'(dec_mem[1]), 32'h6A);
    end
    scen1_flag = 1'b0;
  endtask

  task automatic reset_mid_run();
    int n_exp, cyc;
    bit exp_fail, hit;
    prepare(0, n_exp, exp_fail);
    load_mem();
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (wren_decrypt && mem_sel_decrypt == 2'b11 && address_decrypt == 8'd4) hit = 1'b1;
    end
    check("byte4_write_seen", 32'(hit), 1);
    // WR_D(4) -> INC_I -> RD_SI x3 -> RD_SJ: sixth cycle is mid RD_SJ
    repeat (6) @(negedge clk);
    check("mid_rd_sj_sel", 32'(mem_sel_decrypt), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_abort_outputs",
          32'({busy, done, fail, wren_decrypt, mem_sel_decrypt, address_decrypt, data_decrypt}), 0);
    reset = 1'b0;
    exp_q.delete();
    run_once(0, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    load_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({busy, done, fail, wren_decrypt, mem_sel_decrypt, address_decrypt, data_decrypt}), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    run_once(0, 1'b0, 1'b1);   // known vectors, full-length latency
    run_once(0, 1'b1, 1'b0);   // start pulses while busy are ignored
    run_once(1, 1'b0, 1'b0);   // uppercase byte 3
    run_once(0, 1'b0, 1'b0);   // fail cleared by the next start
    reset_mid_run();
    repeat (2) run_once(0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
